core_run_ctrl: RTL and testbench

Run/step sequencer for the MIPS core. Replaces the switch-driven combinational clock mux with a single-domain clock-enable generator: the core runs on the system clock and advances only on `core_ce` pulses. Pulses come at one of three selectable rates, one per debounced button press, or stop at a PC breakpoint. It sits between the board switches/button and `mips_top`, and also exports state for the OLED/LED status display.

---
 rtl/core_run_ctrl.sv | 137 +++++++++++++
 tb/tb_core_run_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl.sv
// Run/step clock-enable sequencer for the MIPS core: rate prescaler, debounced step button, PC breakpoint.
// Optional breakpoint compare and BREAK state are enabled by defining CORE_BREAKPOINT_EN.
module core_run_ctrl #(
  parameter int unsigned DIV_FAST        = 100,
  parameter int unsigned DIV_MED         = 20000,
  parameter int unsigned DIV_SLOW        = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  mode_i,
  input  logic        step_btn_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] bp_addr_i,
  input  logic        bp_valid_i,
  output logic        core_ce_o,
  output logic [1:0]  state_o,
  output logic [31:0] ce_count_o
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic        core_ce_q, core_ce_d;
  logic [31:0] ce_count_q, ce_count_d;
  logic        sync1_q, sync2_q;
  logic        btn_level_q, btn_level_d;
  logic [31:0] db_cnt_q, db_cnt_d;
  logic        press_q, press_d;
  logic [31:0] div_q, div_sel;
  logic [31:0] pre_cnt_q, pre_cnt_d;
  logic        div_change, tick, bp_hit;

  // Debounced level only follows the synchronized button after an unbroken run of differing samples.
  always_comb begin
    btn_level_d = btn_level_q;
    db_cnt_d    = '0;
    press_d     = 1'b0;
    if (sync2_q != btn_level_q) begin
      if (db_cnt_q == 32'(DEBOUNCE_CYCLES - 1)) begin
        btn_level_d = sync2_q;
        press_d     = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 32'd1;
      end
    end
  end

  // Manual mode keeps the last divider so dropping to 000 never looks like a rate change.
  always_comb begin
    div_sel = div_q;
    if (mode_i[2])      div_sel = 32'(DIV_FAST);
    else if (mode_i[1]) div_sel = 32'(DIV_MED);
    else if (mode_i[0]) div_sel = 32'(DIV_SLOW);
  end

  assign div_change = (div_sel != div_q);
  assign tick       = (state_q == ST_RUN) && !div_change && (pre_cnt_q == div_sel - 32'd1);
  assign pre_cnt_d  = ((state_q != ST_RUN) || div_change || tick) ? '0 : pre_cnt_q + 32'd1;

`ifdef CORE_BREAKPOINT_EN
  assign bp_hit = bp_valid_i && (pc_i == bp_addr_i);
`else
  logic bp_unused;
  assign bp_unused = ^{pc_i, bp_addr_i, bp_valid_i};
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    core_ce_d = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (mode_i != 3'b000) begin
          state_d = ST_RUN;
        end else if (press_q) begin
          state_d   = ST_STEP;
          core_ce_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (mode_i == 3'b000) begin
          state_d = ST_STOP;
        end else if (tick) begin
          if (bp_hit) state_d   = ST_BREAK;
          else        core_ce_d = 1'b1;
        end
      end
      ST_STEP: state_d = ST_STOP;
      ST_BREAK: begin
        if (press_q) begin
          state_d   = ST_STEP;
          core_ce_d = 1'b1;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  assign ce_count_d = ce_count_q + {31'd0, core_ce_d};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_STOP;
      core_ce_q   <= 1'b0;
      ce_count_q  <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      btn_level_q <= 1'b0;
      db_cnt_q    <= '0;
      press_q     <= 1'b0;
      div_q       <= 32'(DIV_SLOW);
      pre_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      core_ce_q   <= core_ce_d;
      ce_count_q  <= ce_count_d;
      sync1_q     <= step_btn_i;
      sync2_q     <= sync1_q;
      btn_level_q <= btn_level_d;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      div_q       <= div_sel;
      pre_cnt_q   <= pre_cnt_d;
    end
  end

  assign core_ce_o  = core_ce_q;
  assign state_o    = state_q;
  assign ce_count_o = ce_count_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with small dividers; breakpoint expectations follow CORE_BREAKPOINT_EN.
module tb_core_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mode;
  logic        stepBtn;
  logic [31:0] pc;
  logic [31:0] bpAddr;
  logic        bpValid;
  logic        coreCe;
  logic [1:0]  state;
  logic [31:0] ceCount;

  int vectors     = 0;
  int miscompares = 0;
  int pulses;
  logic found;

  core_run_ctrl #(
    .DIV_FAST(4),
    .DIV_MED(8),
    .DIV_SLOW(16),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .mode_i(mode),
    .step_btn_i(stepBtn),
    .pc_i(pc),
    .bp_addr_i(bpAddr),
    .bp_valid_i(bpValid),
    .core_ce_o(coreCe),
    .state_o(state),
    .ce_count_o(ceCount)
  );

  always #5 clk = ~clk;

  // Core model: PC advances by one instruction per enable, well before the next tick edge.
  always @(negedge clk) begin
    if (coreCe === 1'b1) pc = pc + 32'd4;
  end

  task automatic applyStimulus(input logic [2:0] m, input logic b);
    mode    = m;
    stepBtn = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    pc      = 32'd0;
    bpAddr  = 32'h10;
    bpValid = 1'b0;
    applyStimulus(3'b000, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset_ce", 32'(coreCe), 32'd0);
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_count", ceCount, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fast rate: RUN the next cycle, first pulse 4 cycles after RUN, then every 4.
    applyStimulus(3'b100, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) checkOutput("run_entry", 32'(state), 32'd1);
      checkOutput("fast_ce", 32'(coreCe), 32'((i >= 5) && (i % 4 == 1)));
    end
    checkOutput("fast_count", ceCount, 32'd9);

    // Medium rate: prescaler restarts, spacing becomes 8.
    applyStimulus(3'b010, 1'b0);
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      checkOutput("med_ce", 32'(coreCe), 32'((j >= 9) && (j % 8 == 1)));
    end
    checkOutput("med_count", ceCount, 32'd11);
    @(negedge clk);
    checkOutput("med_ce_pulse", 32'(coreCe), 32'd1);

    // Asynchronous reset in the middle of a pulse.
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_ce", 32'(coreCe), 32'd0);
    checkOutput("async_rst_state", 32'(state), 32'd0);
    checkOutput("async_rst_count", ceCount, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rst_hold_ce", 32'(coreCe), 32'd0);
      checkOutput("rst_hold_count", ceCount, 32'd0);
    end
    applyStimulus(3'b000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Bouncing button then a firm hold gives exactly one step.
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(3'b000, (k % 2) == 0);
      @(negedge clk);
      pulses += int'(coreCe);
    end
    applyStimulus(3'b000, 1'b1);
    repeat (10) begin
      @(negedge clk);
      pulses += int'(coreCe);
    end
    checkOutput("step_pulses", 32'(pulses), 32'd1);
    checkOutput("step_count", ceCount, 32'd1);
    checkOutput("step_back_stop", 32'(state), 32'd0);

    applyStimulus(3'b000, 1'b0);
    repeat (8) begin
      @(negedge clk);
      pulses += int'(coreCe);
    end
    applyStimulus(3'b000, 1'b1);
    repeat (10) begin
      @(negedge clk);
      pulses += int'(coreCe);
    end
    checkOutput("restep_pulses", 32'(pulses), 32'd2);
    checkOutput("restep_count", ceCount, 32'd2);
    applyStimulus(3'b000, 1'b0);
    repeat (8) @(negedge clk);

    // Breakpoint at 0x10 with the PC model advancing 4 per pulse.
    rst     = 1'b1;
    pc      = 32'd0;
    bpValid = 1'b1;
    bpAddr  = 32'h10;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(3'b100, 1'b0);
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      pulses += int'(coreCe);
    end
`ifdef CORE_BREAKPOINT_EN
    checkOutput("bp_pulses", 32'(pulses), 32'd4);
    checkOutput("bp_state", 32'(state), 32'd3);
    checkOutput("bp_pc", pc, 32'h10);
    checkOutput("bp_count", ceCount, 32'd4);
    applyStimulus(3'b010, 1'b0);
    bpValid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("bp_hold_state", 32'(state), 32'd3);
    checkOutput("bp_hold_count", ceCount, 32'd4);
    bpValid = 1'b1;
    applyStimulus(3'b100, 1'b1);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      pulses += int'(coreCe);
    end
    checkOutput("bp_step_pulses", 32'(pulses), 32'd1);
    checkOutput("bp_step_pc", pc, 32'h14);
    checkOutput("bp_resume_state", 32'(state), 32'd1);
    checkOutput("bp_step_count", ceCount, 32'd5);
`else
    checkOutput("nobp_pulses", 32'(pulses), 32'd7);
    checkOutput("nobp_state", 32'(state), 32'd1);
    checkOutput("nobp_pc", pc, 32'h1C);
    checkOutput("nobp_count", ceCount, 32'd7);
`endif
    applyStimulus(3'b100, 1'b0);
    bpValid = 1'b0;
    repeat (8) @(negedge clk);

    // Counter wrap: preload all ones just after a pulse, the next pulse must roll over to zero.
    found = 1'b0;
    for (int w = 0; w < 8 && !found; w++) begin
      @(negedge clk);
      if (coreCe === 1'b1) found = 1'b1;
    end
    checkOutput("wrap_align", 32'(found), 32'd1);
    force dut.ce_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.ce_count_q;
    #1;
    checkOutput("wrap_forced", ceCount, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    checkOutput("wrap_ce", 32'(coreCe), 32'd1);
    checkOutput("wrap_zero", ceCount, 32'd0);

    // Dropping to manual on the exact tick cycle: stop wins, no pulse.
    repeat (3) @(negedge clk);
    applyStimulus(3'b000, 1'b0);
    @(negedge clk);
    checkOutput("collide_ce", 32'(coreCe), 32'd0);
    checkOutput("collide_state", 32'(state), 32'd0);
    checkOutput("collide_count", ceCount, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
